// File: rtl/pack_rq_stream.sv
`default_nettype none
// ============================================================================
//  Module      : pack_rq_stream
//  Description : Streaming packer for Rq polynomials. Takes one COEF_W-bit
//                coefficient per handshake and emits an LSB-first packed
//                byte stream; the final (zero-padded) byte of each frame is
//                flagged with out_last.
//                Optional macro PACK_RQ_BITREV_EN: bit-reverse each output
//                byte (MSB-first on-wire order).
//  Revision    : 1.0 - initial release
// ============================================================================
module pack_rq_stream #(
    parameter int COEF_W = 13,
    parameter int N_COEF = 700,
    parameter int BYTE_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [COEF_W-1:0] in_coef,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BYTE_W-1:0] out_data,
    output logic              out_last,
    output logic              busy
);

    // The accumulator never holds more than BYTE_W-1 leftover bits plus one coefficient.
    localparam int c_ACC_W  = COEF_W + BYTE_W - 1;
    localparam int c_BCNT_W = $clog2(c_ACC_W + 1);
    localparam int c_CCNT_W = $clog2(N_COEF + 1);

    localparam logic [c_BCNT_W-1:0] c_BYTE_BITS   = c_BCNT_W'(BYTE_W);
    localparam logic [c_BCNT_W-1:0] c_COEF_BITS   = c_BCNT_W'(COEF_W);
    localparam logic [c_CCNT_W-1:0] c_FRAME_COEFS = c_CCNT_W'(N_COEF);
    localparam logic [c_CCNT_W-1:0] c_COEF_ONE    = c_CCNT_W'(1);

    logic [c_ACC_W-1:0]  r_acc;
    logic [c_BCNT_W-1:0] r_bit_cnt;
    logic [c_CCNT_W-1:0] r_coef_cnt;

    logic                w_frame_full;
    logic                w_has_bits;
    logic                w_byte_ready;
    logic                w_pop;
    logic                w_push;
    logic [c_ACC_W-1:0]  w_acc_popped;
    logic [c_ACC_W-1:0]  w_acc_next;
    logic [c_BCNT_W-1:0] w_cnt_popped;
    logic [c_BCNT_W-1:0] w_cnt_next;
    logic [c_CCNT_W-1:0] w_coef_next;

    // All handshake outputs decode the state registers only, so there is no
    // combinational path from in_* to out_* or from ready to valid.
    assign w_frame_full = (r_coef_cnt == c_FRAME_COEFS);
    assign w_has_bits   = (r_bit_cnt != '0);
    assign w_byte_ready = (r_bit_cnt >= c_BYTE_BITS);

    assign in_ready  = !w_byte_ready && !w_frame_full;
    assign out_valid = w_byte_ready || (w_frame_full && w_has_bits);
    assign out_last  = out_valid && w_frame_full && (r_bit_cnt <= c_BYTE_BITS);
    assign busy      = (r_coef_cnt != '0) || w_has_bits;

    assign w_pop  = out_valid && out_ready;
    assign w_push = in_valid && in_ready;

    // Next-state datapath: drain one symbol first, then append the new
    // coefficient directly above whatever bits remain.
    always_comb begin
        w_acc_popped = r_acc;
        w_cnt_popped = r_bit_cnt;
        if (w_pop) begin
            w_acc_popped = r_acc >> BYTE_W;
            w_cnt_popped = w_byte_ready ? (r_bit_cnt - c_BYTE_BITS) : '0;
        end

        w_acc_next  = w_acc_popped;
        w_cnt_next  = w_cnt_popped;
        w_coef_next = r_coef_cnt;
        if (w_push) begin
            // Push only happens with fewer than BYTE_W bits left, so the
            // shifted coefficient always fits in the accumulator.
            w_acc_next  = w_acc_popped | (c_ACC_W'(in_coef) << w_cnt_popped);
            w_cnt_next  = w_cnt_popped + c_COEF_BITS;
            w_coef_next = r_coef_cnt + c_COEF_ONE;
        end

        // Handing over the last byte closes the frame; push cannot coincide
        // because in_ready is low while the frame is full.
        if (w_pop && out_last) begin
            w_coef_next = '0;
        end
    end

    // State registers: async reset, synchronous frame abort via clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc      <= '0;
            r_bit_cnt  <= '0;
            r_coef_cnt <= '0;
        end else if (clear) begin
            r_acc      <= '0;
            r_bit_cnt  <= '0;
            r_coef_cnt <= '0;
        end else begin
            r_acc      <= w_acc_next;
            r_bit_cnt  <= w_cnt_next;
            r_coef_cnt <= w_coef_next;
        end
    end

`ifdef PACK_RQ_BITREV_EN
    // MSB-first on-wire convention: mirror the low symbol of the accumulator.
    for (genvar j = 0; j < BYTE_W; j++) begin : g_bitrev
        assign out_data[BYTE_W-1-j] = r_acc[j];
    end
`else
    // Natural LSB-first order; bits above bit_cnt are always zero, which
    // provides the padding of the final byte.
    assign out_data = r_acc[BYTE_W-1:0];
`endif

endmodule
`default_nettype wire
